// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu : iterative RV32M multiply/divide unit for the execute stage.
//
// One operation is accepted per start pulse while idle. Multiplies use an
// unsigned shift-add over operand magnitudes; divides use restoring division
// over magnitudes. Both retire STEP_BITS bits per CALC cycle, and the FIX
// state applies sign correction and registers the result. Divide-by-zero and
// signed overflow skip CALC and go straight to FIX.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start_i          operation request, sampled only while idle
//   op_i             funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   src1_i, src2_i   rs1 / rs2 operands
//   w_reg_addr_i     destination register
//   flush_i          abort the operation in flight
//   busy_o           high whenever the unit is not idle
//   done_o           one-cycle result-valid pulse
//   w_reg_enable_o   done_o qualified by a non-zero destination
//   w_reg_addr_o     destination of the last result
//   w_reg_data_o     last result
// ---------------------------------------------------------------------------
module ex_mdu #(
    parameter int DATA_WIDTH     = 32,
    parameter int STEP_BITS      = 1,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [2:0]                op_i,
    input  logic [DATA_WIDTH-1:0]     src1_i,
    input  logic [DATA_WIDTH-1:0]     src2_i,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      w_reg_enable_o,
    output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_o,
    output logic [DATA_WIDTH-1:0]     w_reg_data_o
);

    localparam int W     = DATA_WIDTH;
    localparam int S     = STEP_BITS;
    localparam int N     = W / S;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic                      neg_q, neg_d;
    logic                      remNeg_q, remNeg_d;
    logic                      special_q, special_d;
    logic [W-1:0]              hi_q, hi_d;
    logic [W-1:0]              lo_q, lo_d;
    logic [W-1:0]              b_q, b_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      done_q, done_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [W-1:0]              data_q, data_d;

    // Operand decode used only on the accepting edge
    logic         s1Signed, s2Signed, src1Neg, src2Neg;
    logic         divZero, overflow;
    logic [W-1:0] abs1, abs2, specialRes;

    always_comb begin
        s1Signed   = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
        s2Signed   = op_i[2] ? ~op_i[0] : ~op_i[1];
        src1Neg    = s1Signed & src1_i[W-1];
        src2Neg    = s2Signed & src2_i[W-1];
        abs1       = src1Neg ? -src1_i : src1_i;
        abs2       = src2Neg ? -src2_i : src2_i;
        divZero    = op_i[2] & (src2_i == '0);
        overflow   = op_i[2] & ~op_i[0] & (src1_i == MOST_NEG) & (src2_i == '1);
        // Divide by zero: quotient all-ones, remainder = dividend.
        // Overflow: quotient = most-negative (== src1), remainder = 0.
        if (divZero)
            specialRes = op_i[1] ? src1_i : '1;
        else
            specialRes = op_i[1] ? '0 : src1_i;
    end

    // One CALC step of both algorithms; the op decides which one is kept.
    // hi/lo hold the partial product, or remainder/dividend-shifting-to-quotient.
    logic [W+S-1:0] mulPart, mulAcc;
    logic [2*W-1:0] mulShift;
    logic [W:0]     divTrial;
    logic [W-1:0]   divRem, divQuo;

    always_comb begin
        mulPart  = {{S{1'b0}}, b_q} * {{W{1'b0}}, lo_q[S-1:0]};
        mulAcc   = {{S{1'b0}}, hi_q} + mulPart;
        mulShift = (2*W)'({mulAcc, lo_q} >> S);

        divRem   = hi_q;
        divQuo   = lo_q;
        divTrial = '0;
        for (int i = 0; i < S; i++) begin
            divTrial = {divRem, divQuo[W-1]};
            divQuo   = {divQuo[W-2:0], 1'b0};
            if (divTrial >= {1'b0, b_q}) begin
                divTrial  = divTrial - {1'b0, b_q};
                divQuo[0] = 1'b1;
            end
            divRem = divTrial[W-1:0];
        end
    end

    // Sign correction and result selection for FIX
    logic [2*W-1:0] prodFix;
    logic [W-1:0]   mulRes, quoRes, remRes, fixRes;

    always_comb begin
        prodFix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        mulRes  = (op_q[1:0] == 2'b00) ? prodFix[W-1:0] : prodFix[2*W-1:W];
        quoRes  = neg_q ? -lo_q : lo_q;
        remRes  = remNeg_q ? -hi_q : hi_q;
        if (special_q)
            fixRes = lo_q;
        else if (op_q[2])
            fixRes = op_q[1] ? remRes : quoRes;
        else
            fixRes = mulRes;
    end

    // Next-state logic: accept in IDLE, iterate in CALC, publish in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        remNeg_d  = remNeg_q;
        special_d = special_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d     = op_i;
                    rd_d     = w_reg_addr_i;
                    neg_d    = src1Neg ^ src2Neg;
                    remNeg_d = src1Neg;
                    hi_d     = '0;
                    b_d      = abs2;
                    cnt_d    = CNT_INIT;
                    if (divZero || overflow) begin
                        special_d = 1'b1;
                        lo_d      = specialRes;
                        state_d   = S_FIX;
                    end else begin
                        special_d = 1'b0;
                        lo_d      = abs1;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d = op_q[2] ? divRem : mulShift[2*W-1:W];
                    lo_d = op_q[2] ? divQuo : mulShift[W-1:0];
                    if (cnt_q == '0)
                        state_d = S_FIX;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    data_d = fixRes;
                    addr_d = rd_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            remNeg_q  <= 1'b0;
            special_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            remNeg_q  <= remNeg_d;
            special_q <= special_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign w_reg_enable_o = done_q & (addr_q != '0);
    assign w_reg_addr_o   = addr_q;
    assign w_reg_data_o   = data_q;

endmodule

// File: tb/tb_ex_mdu.sv
// ---------------------------------------------------------------------------
// tb_ex_mdu : directed testbench for ex_mdu with default parameters.
// Expected results and done cycles are hand-computed constants; cycle 0 is
// the start edge, so a normal operation finishes at cycle 33 and a special
// case (divide by zero / overflow) at cycle 1.
// ---------------------------------------------------------------------------
module tb_ex_mdu;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  w_reg_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic        w_reg_enable_o;
    logic [4:0]  w_reg_addr_o;
    logic [31:0] w_reg_data_o;

    int vectors    = 0;
    int miscompares = 0;

    ex_mdu #(
        .DATA_WIDTH    (32),
        .STEP_BITS     (1),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .w_reg_addr_i  (w_reg_addr_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .w_reg_enable_o(w_reg_enable_o),
        .w_reg_addr_o  (w_reg_addr_o),
        .w_reg_data_o  (w_reg_data_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse on the falling edge; returns 1 ns after the start edge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        op_i         = op;
        src1_i       = a;
        src2_i       = b;
        w_reg_addr_i = rd;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Start an operation, wait (bounded) for done_o, check cycle and outputs
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] expData, input int expCycle);
        int  cyc;
        bit  seen;
        applyStimulus(op, a, b, rd);
        checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) seen = 1'b1;
        end
        checkOutput({tag, "_cycle"}, cyc, expCycle);
        checkOutput({tag, "_data"}, w_reg_data_o, expData);
        checkOutput({tag, "_addr"}, {27'd0, w_reg_addr_o}, {27'd0, rd});
        checkOutput({tag, "_wen"}, {31'd0, w_reg_enable_o}, {31'd0, (rd != 5'd0)});
    endtask

    initial begin
        int  cyc;
        bit  sawDone;

        rst          = 1'b1;
        start_i      = 1'b0;
        flush_i      = 1'b0;
        op_i         = 3'd0;
        src1_i       = '0;
        src2_i       = '0;
        w_reg_addr_i = '0;

        #12;
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("rst_data", w_reg_data_o, 32'd0);
        checkOutput("rst_addr", {27'd0, w_reg_addr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply family
        runOp("mul_7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        // Output hold: pulse ends, data and address remain
        @(posedge clk);
        #1;
        checkOutput("hold_done", {31'd0, done_o}, 32'd0);
        checkOutput("hold_wen", {31'd0, w_reg_enable_o}, 32'd0);
        checkOutput("hold_data", w_reg_data_o, 32'hFFFFFFEB);
        checkOutput("hold_addr", {27'd0, w_reg_addr_o}, 32'd5);

        runOp("mulh", 3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 32'h00000000, 33);
        runOp("mulhu", 3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h7FFFFFFF, 33);
        runOp("mulhsu", 3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000, 33);
        runOp("mul_rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 33);

        // Divide family
        runOp("div_-7/2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 33);
        runOp("rem_-7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 33);
        runOp("divu_100/7", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33);
        runOp("remu_100/7", 3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 33);

        // Special cases finish at cycle 1
        runOp("divu_5/0", 3'd5, 32'd5, 32'd0, 5'd14, 32'hFFFFFFFF, 1);
        runOp("rem_5/0", 3'd6, 32'd5, 32'd0, 5'd15, 32'd5, 1);
        runOp("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        runOp("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1);

        // Flush at cycle 10 of a DIV: idle at cycle 11, no result, outputs kept
        applyStimulus(3'd4, 32'd1000, 32'd3, 5'd20);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_busy", {31'd0, busy_o}, 32'd0);
        sawDone = done_o;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            sawDone = sawDone | done_o;
        end
        checkOutput("flush_nodone", {31'd0, sawDone}, 32'd0);
        checkOutput("flush_data", w_reg_data_o, 32'd0);
        checkOutput("flush_addr", {27'd0, w_reg_addr_o}, 32'd17);

        // Second start at cycle 5 of a MUL is ignored
        applyStimulus(3'd0, 32'd6, 32'd9, 5'd7);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
        end
        op_i    = 3'd5;
        src1_i  = 32'd5;
        src2_i  = 32'd0;
        w_reg_addr_i = 5'd9;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cyc = 6;
        while (!done_o && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("ign_cycle", cyc, 33);
        checkOutput("ign_data", w_reg_data_o, 32'd54);
        checkOutput("ign_addr", {27'd0, w_reg_addr_o}, 32'd7);
        @(posedge clk);
        #1;
        checkOutput("ign_noqueue", {31'd0, busy_o}, 32'd0);

        // Reset mid-CALC clears outputs without waiting for a clock edge
        applyStimulus(3'd0, 32'd3, 32'd4, 5'd8);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("arst_done", {31'd0, done_o}, 32'd0);
        checkOutput("arst_wen", {31'd0, w_reg_enable_o}, 32'd0);
        checkOutput("arst_data", w_reg_data_o, 32'd0);
        checkOutput("arst_addr", {27'd0, w_reg_addr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unit is usable again after reset
        runOp("post_rst", 3'd5, 32'd81, 32'd9, 5'd4, 32'd9, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
